// File: rtl/wb_ram_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter sharing a single RAM slave port.
// Round-robin grant, per-grant outstanding tracking and a watchdog that turns a hung slave into a bus error.
module wb_ram_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_bus,
    input  logic        rst_bus,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    output logic        m0_stall_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic        m1_stall_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    input  logic        s_stall_i
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, FLUSH} state_t;

    localparam logic [3:0]  MAX_CNT = 4'(MAX_OUT);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        last;
    logic [3:0]  out_cnt;
    logic [15:0] wd_cnt;

    logic        own0;
    logic        own1;
    logic        owning;
    logic        own_cyc;
    logic        own_stb;
    logic        own_we;
    logic [31:0] own_adr;
    logic [3:0]  own_sel;
    logic [31:0] own_dat;
    logic        own_stall;
    logic        slave_resp;
    logic        accept;
    logic        timeout;
    logic [3:0]  out_cnt_next;

    assign own0   = (state == OWN0);
    assign own1   = (state == OWN1);
    assign owning = own0 | own1;

    // The grant register alone selects which master's request reaches the slave.
    always_comb begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        own_we  = m0_we_i;
        own_adr = m0_adr_i;
        own_sel = m0_sel_i;
        own_dat = m0_dat_i;
        if (own1) begin
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
            own_we  = m1_we_i;
            own_adr = m1_adr_i;
            own_sel = m1_sel_i;
            own_dat = m1_dat_i;
        end
    end

    assign slave_resp = s_ack_i | s_err_i | s_rty_i;

    assign s_cyc_o = owning & own_cyc;
    assign s_stb_o = owning & own_stb & (out_cnt < MAX_CNT);
    assign s_we_o  = owning & own_we;
    assign s_adr_o = owning ? own_adr : '0;
    assign s_sel_o = owning ? own_sel : '0;
    assign s_dat_o = owning ? own_dat : '0;

    assign accept    = s_stb_o & ~s_stall_i;
    assign own_stall = s_stall_i | (out_cnt == MAX_CNT);
    assign timeout   = owning & (out_cnt != 4'd0) & ~slave_resp & (wd_cnt == WD_LAST);

    // A watchdog expiry is reported as exactly one error to the owner.
    assign m0_stall_o = own0 ? own_stall : 1'b1;
    assign m0_ack_o   = own0 & s_ack_i & ~timeout;
    assign m0_err_o   = own0 & (s_err_i | timeout);
    assign m0_rty_o   = own0 & s_rty_i;
    assign m0_dat_o   = own0 ? s_dat_i : '0;

    assign m1_stall_o = own1 ? own_stall : 1'b1;
    assign m1_ack_o   = own1 & s_ack_i & ~timeout;
    assign m1_err_o   = own1 & (s_err_i | timeout);
    assign m1_rty_o   = own1 & s_rty_i;
    assign m1_dat_o   = own1 ? s_dat_i : '0;

    always_comb begin
        out_cnt_next = out_cnt;
        if (accept && !slave_resp)
            out_cnt_next = out_cnt + 4'd1;
        else if (!accept && slave_resp && out_cnt != 4'd0)
            out_cnt_next = out_cnt - 4'd1;
    end

    // Leaving a grant for any reason drops all outstanding bookkeeping; late responses are never forwarded.
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            state   <= IDLE;
            last    <= 1'b1;
            out_cnt <= 4'd0;
            wd_cnt  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    out_cnt <= 4'd0;
                    wd_cnt  <= 16'd0;
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state <= OWN0;
                        last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state <= OWN1;
                        last  <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (timeout) begin
                        state   <= FLUSH;
                        out_cnt <= 4'd0;
                        wd_cnt  <= 16'd0;
                    end else if (!own_cyc) begin
                        state   <= IDLE;
                        out_cnt <= 4'd0;
                        wd_cnt  <= 16'd0;
                    end else begin
                        out_cnt <= out_cnt_next;
                        if (slave_resp || out_cnt == 4'd0)
                            wd_cnt <= 16'd0;
                        else
                            wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                FLUSH: begin
                    state   <= IDLE;
                    out_cnt <= 4'd0;
                    wd_cnt  <= 16'd0;
                end
                default: begin
                    state   <= IDLE;
                    out_cnt <= 4'd0;
                    wd_cnt  <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: per-cycle vector table for grant/pipelining behaviour,
// then hand-written sequences for abort, watchdog timeout and asynchronous reset.
module tb_wb_ram_arbiter;

    localparam logic [31:0] M0_ADR = 32'h0000_0010;
    localparam logic [31:0] M1_ADR = 32'h0000_0020;
    localparam logic [31:0] M0_DAT = 32'h0BAD_F00D;
    localparam logic [31:0] M1_DAT = 32'h5555_AAAA;
    localparam logic [3:0]  M0_SEL = 4'hF;
    localparam logic [3:0]  M1_SEL = 4'h3;
    localparam logic [31:0] J      = 32'hC0FF_EE00;
    localparam int          NVEC   = 36;

    logic        clk_bus;
    logic        rst_bus;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m0_stall_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o, m1_rty_o, m1_stall_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_ack_i, s_err_i, s_rty_i, s_stall_i;

    int n_checks = 0;
    int n_pass   = 0;

    wb_ram_arbiter #(.MAX_OUT(4), .TIMEOUT(8)) dut (
        .clk_bus(clk_bus), .rst_bus(rst_bus),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_stall_o(m0_stall_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_stall_o(m1_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_stall_i(s_stall_i)
    );

    initial clk_bus = 1'b0;
    always #5 clk_bus = ~clk_bus;

    // resp/r0/r1 codes: 0 none, 1 ack, 2 err, 3 rty. own: 0 none, 1 master 0, 2 master 1.
    typedef struct {
        string       name;
        bit          rst, m0c, m0s, m1c, m1s;
        bit [1:0]    resp;
        bit          stall;
        logic [31:0] sdat;
        bit [1:0]    own;
        bit          scyc, sstb, st0, st1;
        bit [1:0]    r0, r1;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input string name, input bit rst, m0c, m0s, m1c, m1s,
                                input bit [1:0] resp, input bit stall, input logic [31:0] sdat,
                                input bit [1:0] own, input bit scyc, sstb, st0, st1,
                                input bit [1:0] r0, r1);
        vec_t v;
        v.name = name; v.rst = rst; v.m0c = m0c; v.m0s = m0s; v.m1c = m1c; v.m1s = m1s;
        v.resp = resp; v.stall = stall; v.sdat = sdat; v.own = own;
        v.scyc = scyc; v.sstb = sstb; v.st0 = st0; v.st1 = st1; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    function automatic logic [2:0] resp_bits(input bit [1:0] code);
        case (code)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic tick;
        @(posedge clk_bus);
        #1;
    endtask

    task automatic drive(input bit m0c, m0s, m1c, m1s, input bit [1:0] resp, input bit stall);
        m0_cyc_i = m0c; m0_stb_i = m0s; m1_cyc_i = m1c; m1_stb_i = m1s;
        {s_ack_i, s_err_i, s_rty_i} = resp_bits(resp);
        s_stall_i = stall;
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_bus = v.rst;
        drive(v.m0c, v.m0s, v.m1c, v.m1s, v.resp, v.stall);
        s_dat_i = v.sdat;
    endtask

    task automatic checkVector(input vec_t v);
        logic [31:0] e_adr, e_wdat, e_d0, e_d1;
        logic [4:0]  e_ctl;
        e_adr = '0; e_wdat = '0; e_ctl = '0;
        if (v.own == 2'd1) begin
            e_adr = M0_ADR; e_wdat = M0_DAT; e_ctl = {1'b0, M0_SEL};
        end else if (v.own == 2'd2) begin
            e_adr = M1_ADR; e_wdat = M1_DAT; e_ctl = {1'b1, M1_SEL};
        end
        e_d0 = (v.own == 2'd1) ? v.sdat : 32'd0;
        e_d1 = (v.own == 2'd2) ? v.sdat : 32'd0;
        checkOutput({v.name, ".s_cyc"},   32'(s_cyc_o), 32'(v.scyc));
        checkOutput({v.name, ".s_stb"},   32'(s_stb_o), 32'(v.sstb));
        checkOutput({v.name, ".stall0"},  32'(m0_stall_o), 32'(v.st0));
        checkOutput({v.name, ".stall1"},  32'(m1_stall_o), 32'(v.st1));
        checkOutput({v.name, ".resp0"},   32'({m0_ack_o, m0_err_o, m0_rty_o}), 32'(resp_bits(v.r0)));
        checkOutput({v.name, ".resp1"},   32'({m1_ack_o, m1_err_o, m1_rty_o}), 32'(resp_bits(v.r1)));
        checkOutput({v.name, ".dat0"},    m0_dat_o, e_d0);
        checkOutput({v.name, ".dat1"},    m1_dat_o, e_d1);
        checkOutput({v.name, ".s_adr"},   s_adr_o, e_adr);
        checkOutput({v.name, ".s_wesel"}, 32'({s_we_o, s_sel_o}), 32'(e_ctl));
        checkOutput({v.name, ".s_dat"},   s_dat_o, e_wdat);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] bench hung");
    end

    initial begin
        vecs[0]  = mk("t1_req",     0, 1,1,0,0, 0,0, J,            0, 0,0,1,1, 0,0);
        vecs[1]  = mk("t1_acc",     0, 1,1,0,0, 0,0, J,            1, 1,1,0,1, 0,0);
        vecs[2]  = mk("t1_wait",    0, 1,0,0,0, 0,0, J,            1, 1,0,0,1, 0,0);
        vecs[3]  = mk("t1_ack",     0, 1,0,0,0, 1,0, 32'hDEADBEEF, 1, 1,0,0,1, 1,0);
        vecs[4]  = mk("t1_rel",     0, 0,0,0,0, 0,0, J,            1, 0,0,0,1, 0,0);
        vecs[5]  = mk("t1_idle",    0, 0,0,0,0, 0,0, J,            0, 0,0,1,1, 0,0);
        vecs[6]  = mk("t2_rst",     1, 0,0,0,0, 0,0, J,            0, 0,0,1,1, 0,0);
        vecs[7]  = mk("t2_both",    0, 1,1,1,1, 0,0, J,            0, 0,0,1,1, 0,0);
        vecs[8]  = mk("t2_stall",   0, 1,1,1,1, 0,1, J,            1, 1,1,1,1, 0,0);
        vecs[9]  = mk("t2_acc0",    0, 1,1,1,1, 0,0, J,            1, 1,1,0,1, 0,0);
        vecs[10] = mk("t2_ack0",    0, 1,0,1,1, 1,0, 32'h1111_0000, 1, 1,0,0,1, 1,0);
        vecs[11] = mk("t2_rel0",    0, 0,0,1,1, 0,0, J,            1, 0,0,0,1, 0,0);
        vecs[12] = mk("t2_gap",     0, 0,0,1,1, 0,0, J,            0, 0,0,1,1, 0,0);
        vecs[13] = mk("t2_acc1",    0, 0,0,1,1, 0,0, J,            2, 1,1,1,0, 0,0);
        vecs[14] = mk("t2_err1",    0, 0,0,1,0, 2,0, 32'h2222_0000, 2, 1,0,1,0, 0,2);
        vecs[15] = mk("t2_rel1",    0, 0,0,0,0, 0,0, J,            2, 0,0,1,0, 0,0);
        vecs[16] = mk("t2_both2",   0, 1,1,1,1, 0,0, J,            0, 0,0,1,1, 0,0);
        vecs[17] = mk("t2_regrant", 0, 1,1,1,1, 0,0, J,            1, 1,1,0,1, 0,0);
        vecs[18] = mk("t2_ack",     0, 1,0,0,0, 1,0, J,            1, 1,0,0,1, 1,0);
        vecs[19] = mk("t2_rel",     0, 0,0,0,0, 0,0, J,            1, 0,0,0,1, 0,0);
        vecs[20] = mk("p_req",      0, 0,0,1,1, 0,0, J,            0, 0,0,1,1, 0,0);
        vecs[21] = mk("p_acc1",     0, 0,0,1,1, 0,0, J,            2, 1,1,1,0, 0,0);
        vecs[22] = mk("p_acc2",     0, 0,0,1,1, 0,0, J,            2, 1,1,1,0, 0,0);
        vecs[23] = mk("p_acc3",     0, 0,0,1,1, 0,0, J,            2, 1,1,1,0, 0,0);
        vecs[24] = mk("p_acc4",     0, 0,0,1,1, 0,0, J,            2, 1,1,1,0, 0,0);
        vecs[25] = mk("p_full",     0, 0,0,1,1, 0,0, J,            2, 1,0,1,1, 0,0);
        vecs[26] = mk("p_ack1",     0, 0,0,1,1, 1,0, J,            2, 1,0,1,1, 0,1);
        vecs[27] = mk("p_acc5",     0, 0,0,1,1, 0,0, J,            2, 1,1,1,0, 0,0);
        vecs[28] = mk("p_full2",    0, 0,0,1,1, 0,0, J,            2, 1,0,1,1, 0,0);
        vecs[29] = mk("p_ack2",     0, 0,0,1,1, 1,0, J,            2, 1,0,1,1, 0,1);
        vecs[30] = mk("p_acc6",     0, 0,0,1,1, 1,0, J,            2, 1,1,1,0, 0,1);
        vecs[31] = mk("p_ack4",     0, 0,0,1,0, 1,0, J,            2, 1,0,1,0, 0,1);
        vecs[32] = mk("p_rty5",     0, 0,0,1,0, 3,0, J,            2, 1,0,1,0, 0,3);
        vecs[33] = mk("p_ack6",     0, 0,0,1,0, 1,0, J,            2, 1,0,1,0, 0,1);
        vecs[34] = mk("p_rel",      0, 0,0,0,0, 0,0, J,            2, 0,0,1,0, 0,0);
        vecs[35] = mk("p_idle",     0, 0,0,0,0, 0,0, J,            0, 0,0,1,1, 0,0);

        m0_we_i = 1'b0; m0_sel_i = M0_SEL; m0_adr_i = M0_ADR; m0_dat_i = M0_DAT;
        m1_we_i = 1'b1; m1_sel_i = M1_SEL; m1_adr_i = M1_ADR; m1_dat_i = M1_DAT;
        s_dat_i = J;
        rst_bus = 1'b1;
        drive(0,0,0,0, 0,0);
        tick;
        tick;
        @(negedge clk_bus);
        checkOutput("rst.s_bus",  32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'd0);
        checkOutput("rst.s_adr",  s_adr_o, 32'd0);
        checkOutput("rst.s_dat",  s_dat_o, 32'd0);
        checkOutput("rst.stalls", 32'({m0_stall_o, m1_stall_o}), 32'b11);
        checkOutput("rst.resps",  32'({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}), 32'd0);
        checkOutput("rst.dat0",   m0_dat_o, 32'd0);
        checkOutput("rst.dat1",   m1_dat_o, 32'd0);
        checkOutput("rst.out_cnt", 32'(dut.out_cnt), 32'd0);
        tick;
        rst_bus = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk_bus);
            checkVector(vecs[i]);
            tick;
        end

        // Abort: master 0 leaves with two requests in flight; the late acks go nowhere.
        s_dat_i = J;
        drive(1,1,0,0, 0,0); tick;
        drive(1,1,0,0, 0,0); @(negedge clk_bus); checkOutput("ab.acc1", 32'(s_stb_o), 32'd1); tick;
        drive(1,1,0,0, 0,0); @(negedge clk_bus); checkOutput("ab.acc2", 32'(s_stb_o), 32'd1); tick;
        drive(0,0,0,0, 0,0); @(negedge clk_bus); checkOutput("ab.drop_cyc", 32'(s_cyc_o), 32'd0); tick;
        drive(0,0,0,0, 1,0); @(negedge clk_bus);
        checkOutput("ab.late1_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
        checkOutput("ab.late1_cyc",  32'(s_cyc_o), 32'd0);
        checkOutput("ab.out_cnt",    32'(dut.out_cnt), 32'd0);
        tick;
        drive(0,0,1,1, 1,0); @(negedge clk_bus);
        checkOutput("ab.late2_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
        checkOutput("ab.late2_stall1", 32'(m1_stall_o), 32'd1);
        tick;
        drive(0,0,1,0, 0,0); @(negedge clk_bus);
        checkOutput("ab.m1_grant_cyc", 32'(s_cyc_o), 32'd1);
        checkOutput("ab.m1_grant_adr", s_adr_o, M1_ADR);
        checkOutput("ab.m1_grant_stall", 32'(m1_stall_o), 32'd0);
        tick;
        drive(0,0,0,0, 0,0); tick;

        // Watchdog: one accepted request, silent slave, error in the 8th cycle after the accept.
        drive(0,0,1,1, 0,0); tick;
        drive(0,0,1,1, 0,0); @(negedge clk_bus); checkOutput("to.accept", 32'(s_stb_o), 32'd1); tick;
        for (int k = 1; k <= 8; k++) begin
            drive(0,0,1,0, 0,0);
            @(negedge clk_bus);
            checkOutput($sformatf("to.err_k%0d", k), 32'(m1_err_o), 32'(k == 8));
            checkOutput($sformatf("to.ack_k%0d", k), 32'(m1_ack_o), 32'd0);
            checkOutput($sformatf("to.cyc_k%0d", k), 32'(s_cyc_o), 32'd1);
            tick;
        end
        drive(0,0,1,0, 1,0); @(negedge clk_bus);
        checkOutput("to.flush_cyc",   32'(s_cyc_o), 32'd0);
        checkOutput("to.flush_resp",  32'({m1_ack_o, m1_err_o, m0_ack_o, m0_err_o}), 32'd0);
        checkOutput("to.flush_stall", 32'(m1_stall_o), 32'd1);
        tick;
        drive(1,1,1,1, 0,0); @(negedge clk_bus); checkOutput("to.idle_cyc", 32'(s_cyc_o), 32'd0); tick;
        drive(1,0,0,0, 0,0); @(negedge clk_bus);
        checkOutput("to.next_grant_m0", 32'({m0_stall_o, m1_stall_o}), 32'b01);
        checkOutput("to.next_grant_adr", s_adr_o, M0_ADR);
        tick;
        drive(0,0,0,0, 0,0); tick;

        // Asynchronous reset between edges with three requests outstanding.
        drive(1,1,0,0, 0,0); tick;
        for (int k = 0; k < 3; k++) begin
            drive(1,1,0,0, 0,0); tick;
        end
        drive(1,0,0,0, 0,0);
        #2;
        checkOutput("ar.pre_cyc", 32'(s_cyc_o), 32'd1);
        rst_bus = 1'b1;
        #1;
        checkOutput("ar.cyc_now",    32'(s_cyc_o), 32'd0);
        checkOutput("ar.stalls_now", 32'({m0_stall_o, m1_stall_o}), 32'b11);
        tick;
        rst_bus = 1'b0;
        checkOutput("ar.out_cnt", 32'(dut.out_cnt), 32'd0);
        drive(1,1,1,1, 0,0); @(negedge clk_bus);
        checkOutput("ar.idle_stalls", 32'({m0_stall_o, m1_stall_o}), 32'b11);
        tick;
        drive(1,1,1,1, 0,0); @(negedge clk_bus);
        checkOutput("ar.m0_wins", 32'({m0_stall_o, m1_stall_o}), 32'b01);
        checkOutput("ar.m0_adr",  s_adr_o, M0_ADR);
        tick;
        drive(0,0,0,0, 0,0); tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
- Two-master to one-slave pipelined Wishbone arbiter on the clk_bus domain.
- Shares one RAMSlave port (base or ext SRAM) between two requesters, e.g. the instruction-fetch and data ports of SystemOnCat.
- Uses round-robin grant and tracks outstanding transactions per grant.
- Watchdog turns a hung slave into a bus error to the requester.

Parameters:
- MAX_OUT, 4: maximum outstanding (accepted, unanswered) requests per grant; 1..15.
- TIMEOUT, 255: cycles with outstanding>0 and no response before a forced error; 1..65535.

Ports:
- clk_bus  in  1  bus clock
- rst_bus  in  1  reset, asynchronous, active-high
- mN_cyc_i, mN_stb_i, mN_we_i (N=0,1)  in  1 each  master N Wishbone cycle, strobe, write enable
- mN_adr_i  in  32  master N address
- mN_sel_i  in  4  master N byte select
- mN_dat_i  in  32  master N write data
- mN_dat_o  out  32  read data to master N
- mN_ack_o, mN_err_o, mN_rty_o  out  1 each  responses to master N
- mN_stall_o  out  1  stall to master N
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  32  to slave
- s_sel_o  out  4  to slave
- s_dat_o  out  32  to slave
- s_dat_i  in  32  read data from slave
- s_ack_i, s_err_i, s_rty_i  in  1 each  responses from slave
- s_stall_i  in  1  stall from slave

Behaviour:
- Reset (async, rst_bus=1):
  - state=IDLE, last=1, out_cnt=0, wd_cnt=0.
  - All s_* outputs 0.
  - mN_ack/err/rty_o=0, mN_dat_o=0, mN_stall_o=1.
- States: IDLE, OWN0, OWN1, FLUSH. The state register is the grant; all master/slave signal steering is combinational from it.
- IDLE:
  - Only mN_cyc_i=1: go to OWNN.
  - Both requesting: grant the master != last.
  - Neither requesting: stay in IDLE.
  - On grant, last<=N.
  - Grant latency is one cycle: the request in cycle t is seen at the slave at t+1 at the earliest. The master sees stall=1 at t.
- OWNN steering:
  - s_cyc_o = mN_cyc_i.
  - s_stb_o = mN_stb_i & (out_cnt<MAX_OUT).
  - s_we/adr/sel/dat_o pass through from master N.
  - mN_stall_o = s_stall_i | (out_cnt==MAX_OUT).
  - mN_ack/err/rty_o = s_ack/err/rty_i; mN_dat_o = s_dat_i.
- Non-owner master: stall_o=1, responses 0, dat_o=0.
- out_cnt:
  - +1 on accept (s_stb_o & !s_stall_i).
  - -1 on any response (s_ack_i|s_err_i|s_rty_i).
  - Accept and response in the same cycle: unchanged.
  - Never underflows: a response with out_cnt=0 is forwarded, count stays 0.
- Release:
  - Owner drops cyc with out_cnt==0: next state IDLE.
  - Owner drops cyc with out_cnt>0 (abort): next state IDLE, out_cnt<=0, late responses discarded (not forwarded to either master).
  - No back-to-back handover. At least one IDLE cycle with s_cyc_o=0 between grants.
- Watchdog:
  - wd_cnt increments while out_cnt>0 and no response this cycle.
  - wd_cnt clears on any response, or when out_cnt==0.
  - On wd_cnt==TIMEOUT-1 with no response: that cycle drives mN_err_o=1 and mN_ack_o=0.
  - Next state FLUSH; out_cnt<=0; wd_cnt<=0.
- FLUSH:
  - One cycle with s_cyc_o=0, slave responses discarded.
  - Then IDLE; last stays N.
  - The master sees exactly one err for the whole hung burst.
- Reset mid-operation: outputs return to reset values immediately (async). No response is generated for in-flight requests.
- Widths: out_cnt 4 bits, wd_cnt 16 bits.

Test Plan:
- Single master: m0 single read to 0x0000_0010, slave acks 2 cycles after accept with 0xDEAD_BEEF. Required: m0_ack_o pulse, m0_dat_o=0xDEAD_BEEF, m1_stall_o=1 throughout, out_cnt back to 0.
- Contention: after reset both cyc rise in the same cycle. Required: m0 granted first. When m0 releases, one IDLE cycle, then m1 granted. Next simultaneous request is granted to m0 again.
- Pipelining limit: MAX_OUT=4, m1 issues 6 strobes, slave never stalls and withholds acks. Required: exactly 4 accepts, m1_stall_o=1 from the 5th. The 5th is accepted the cycle after the first ack.
- Abort: m0 has 2 outstanding and drops cyc. Required: IDLE next cycle. The slave's late acks do not reach m0 or m1. m1 can be granted after the IDLE cycle.
- Timeout: TIMEOUT=8, m1 has 1 outstanding, slave silent. Required: m1_err_o=1 exactly in cycle 8 after accept, then s_cyc_o=0 for 1 FLUSH cycle, then IDLE.
- Async reset mid-burst: assert rst_bus between clock edges with 3 outstanding. Required: s_cyc_o=0 and both mN_stall_o=1 immediately, out_cnt=0 after release, m0 wins the next contention.
